// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory-access sequencer.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_DREAD,
        S_IREAD,
        S_DRESP,
        S_IRESP
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 15;
    localparam int CNT_W      = $clog2(16);

endpackage

// File: rtl/rd_latency_timer.sv
// Loadable down-counter; o_done is high whenever the count has reached zero.
module rd_latency_timer
    import mem_seq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/mem_sequencer.sv
// Req/ack sequencer arbitrating stores, loads and instruction fetches onto
// synchronous data/instruction memories with a configurable read latency.
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 12,
    parameter int IM_ADDR_W = 8,
    parameter int RD_LAT    = 1
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [ADDR_W-1:0]    fetch_addr,
    output logic                 fetch_ack,
    output logic [DATA_W-1:0]    fetch_data,
    input  logic                 d_rd_req,
    input  logic                 d_wr_req,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [DATA_W-1:0]    d_wdata,
    output logic                 d_ack,
    output logic [DATA_W-1:0]    d_rdata,
    output logic [ADDR_W-1:0]    dm_addr,
    output logic [DATA_W-1:0]    dm_wdata,
    output logic                 dm_wren,
    input  logic [DATA_W-1:0]    dm_q,
    output logic [IM_ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0]    im_q,
    output logic                 busy,
    output logic                 err
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX || IM_ADDR_W > ADDR_W) begin : g_bad_params
        $error("mem_sequencer: RD_LAT must be 1..15 and IM_ADDR_W <= ADDR_W");
    end

    state_t                r_state;
    state_t                w_next;
    logic                  w_load;
    logic                  w_done;
    logic                  w_err_set;
    logic                  w_fetch_oob;
    logic [ADDR_W-1:0]     r_dm_addr;
    logic [DATA_W-1:0]     r_dm_wdata;
    logic [IM_ADDR_W-1:0]  r_im_addr;
    logic [DATA_W-1:0]     r_d_rdata;
    logic [DATA_W-1:0]     r_fetch_data;
    logic                  r_err;

    // Shifting by the full IM width leaves only the bits the IM cannot address.
    assign w_fetch_oob = ((fetch_addr >> IM_ADDR_W) != '0);

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_err_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (d_wr_req) begin
                    w_next    = S_WRITE;
                    w_err_set = d_rd_req;
                end else if (d_rd_req) begin
                    w_next = S_DREAD;
                    w_load = 1'b1;
                end else if (fetch_req) begin
                    w_next    = S_IREAD;
                    w_load    = 1'b1;
                    w_err_set = w_fetch_oob;
                end
            end
            S_WRITE: w_next = S_IDLE;
            S_DREAD: if (w_done) w_next = S_DRESP;
            S_IREAD: if (w_done) w_next = S_IRESP;
            S_DRESP: w_next = S_IDLE;
            S_IRESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_dm_addr    <= '0;
            r_dm_wdata   <= '0;
            r_im_addr    <= '0;
            r_d_rdata    <= '0;
            r_fetch_data <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                if (d_wr_req || d_rd_req) begin
                    r_dm_addr <= d_addr;
                    if (d_wr_req) r_dm_wdata <= d_wdata;
                end else if (fetch_req) begin
                    r_im_addr <= fetch_addr[IM_ADDR_W-1:0];
                end
            end
            if (w_err_set)             r_err        <= 1'b1;
            if (r_state == S_DRESP)    r_d_rdata    <= dm_q;
            if (r_state == S_IRESP)    r_fetch_data <= im_q;
        end
    end

    rd_latency_timer u_timer (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_load     (w_load),
        .i_load_val (CNT_W'(RD_LAT)),
        .o_done     (w_done)
    );

    // Response data is forwarded in the ack cycle and held by the register after.
    assign d_rdata    = (r_state == S_DRESP) ? dm_q : r_d_rdata;
    assign fetch_data = (r_state == S_IRESP) ? im_q : r_fetch_data;
    assign d_ack      = (r_state == S_WRITE) || (r_state == S_DRESP);
    assign fetch_ack  = (r_state == S_IRESP);
    assign dm_wren    = (r_state == S_WRITE);
    assign dm_addr    = r_dm_addr;
    assign dm_wdata   = r_dm_wdata;
    assign im_addr    = r_im_addr;
    assign busy       = (r_state != S_IDLE);
    assign err        = r_err;

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Parametrised memory-access sequencer between the control unit and the synchronous data and instruction memories. It replaces the fixed one-cycle AR/DR memory timing with a req/ack handshake and a configurable read latency. It arbitrates instruction fetches against data loads and stores, and reports protocol and address errors. The control unit stalls on the handshake instead of hard-coding memory wait states.

## Interface
- `DATA_W`, 12, data word width
- `ADDR_W`, 12, data-memory address width
- `IM_ADDR_W`, 8, instruction-memory address width (≤ `ADDR_W`)
- `RD_LAT`, 1, memory read latency in cycles from address driven to `q` valid; legal range 1..15

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `fetch_req`  in  1  instruction fetch request, held until `fetch_ack`
- `fetch_addr`  in  `ADDR_W`  fetch address
- `fetch_ack`  out  1  one-cycle pulse; `fetch_data` valid
- `fetch_data`  out  `DATA_W`  last fetched instruction word, held
- `d_rd_req`  in  1  data load request
- `d_wr_req`  in  1  data store request
- `d_addr`  in  `ADDR_W`  data address
- `d_wdata`  in  `DATA_W`  store data
- `d_ack`  out  1  one-cycle pulse; load data valid or store committed
- `d_rdata`  out  `DATA_W`  last loaded word, held
- `dm_addr`  out  `ADDR_W`  data-memory address
- `dm_wdata`  out  `DATA_W`  data-memory write data
- `dm_wren`  out  1  data-memory write strobe
- `dm_q`  in  `DATA_W`  data-memory read data
- `im_addr`  out  `IM_ADDR_W`  instruction-memory address
- `im_q`  in  `DATA_W`  instruction-memory read data
- `busy`  out  1  high in every state except IDLE
- `err`  out  1  sticky error flag; cleared only by reset

## Operation
- FSM states:
  - IDLE
  - WRITE
  - DREAD (data read wait)
  - IREAD (instruction read wait)
  - DRESP
  - IRESP
- Requests are sampled only in IDLE.
- Priority in IDLE: `d_wr_req` > `d_rd_req` > `fetch_req`. Data access wins because it belongs to the instruction already in flight.
- On acceptance, the address and write data are registered. Later changes on the request inputs are ignored until the ack.
- WRITE:
  - `dm_addr` = registered address, `dm_wdata` = registered data, `dm_wren`=1 for exactly one cycle.
  - `d_ack`=1 in the same cycle; next state IDLE.
- DREAD / IREAD:
  - The registered address is driven on `dm_addr` / `im_addr` (lower `IM_ADDR_W` bits).
  - A down-counter loaded with `RD_LAT` decrements each cycle. At 0 the state moves to DRESP / IRESP.
- DRESP / IRESP:
  - `dm_q` / `im_q` is captured into `d_rdata` / `fetch_data`.
  - The ack pulses for one cycle; next state IDLE.
- Requester must drop req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- Error conditions (the access still proceeds in both cases):
  - `d_rd_req` and `d_wr_req` both high in IDLE: sets `err`; the write is performed.
  - Accepted fetch with `fetch_addr[ADDR_W-1:IM_ADDR_W]` ≠ 0: sets `err`; the fetch uses the truncated address.
- `dm_wren` is never high outside WRITE.
- `dm_addr` and `im_addr` hold their last driven value when idle.

## Timing
- Reset values: state IDLE; all acks 0; `dm_wren` 0; `dm_addr`, `dm_wdata`, `im_addr`, `d_rdata`, `fetch_data` 0; `err` 0; `busy` 0.
- Reset mid-transaction aborts it: no ack, no write strobe, captured data discarded.
- Store latency: req sampled in IDLE at cycle N → `dm_wren` and `d_ack` at N+1.
- Load/fetch latency: req at N → address driven from N+1 → ack and data at N+2+`RD_LAT`.
- Minimum spacing between two accepted requests: one IDLE cycle after each ack.
- A pending lower-priority request waits with no timeout. Starvation of fetch under continuous data traffic is permitted.

## Structure
- Shared package `mem_seq_pkg`: FSM state enum, `RD_LAT` legal-range constants, counter width `CNT_W = $clog2(16)`.
- One sub-module, `rd_latency_timer`: loadable down-counter with a `done` output, instantiated once and shared by DREAD and IREAD.
- Elaboration check: fail if `RD_LAT` < 1, `RD_LAT` > 15, or `IM_ADDR_W` > `ADDR_W`.

## Test plan
- Store at `d_addr`=0x01A, `d_wdata`=0x5C3 → one cycle later `dm_wren`=1 with that address and data, `d_ack`=1, then `busy`=0.
- `RD_LAT`=3, load from 0x040 with the memory model returning 0xABC → `d_ack` at N+5, `d_rdata`=0xABC, held through the following idle cycles.
- `fetch_req` and `d_rd_req` raised in the same cycle → load completes first. Fetch is accepted in the IDLE cycle after `d_ack`. `fetch_ack` arrives with the `im_q` word.
- Fetch at 0x1F3 with `IM_ADDR_W`=8 → `im_addr`=0xF3, `err`=1 and stays 1 through later clean accesses.
- `d_rd_req` and `d_wr_req` high together → write performed, `err`=1, no read.
- `reset` low during DREAD → no `d_ack`; all outputs at reset values the next cycle. A fresh load afterwards completes normally.
